pipelined_divider: RTL
======================

# pipelined_divider

- Fully pipelined integer divider, one result per cycle, parametrised in operand width and in iterations per register stage.
- Adds a per-transaction signed/unsigned mode, divide-by-zero and overflow handling, and an opaque tag carried with each operation.
- Adds a valid/ready handshake on both sides so the whole pipeline stalls under downstream backpressure.
- Sits between the fluid-solver arithmetic front end and the write-back stage, replacing the fixed-width combinational/registered divider.

## Interface
- WIDTH, 32, operand and result width in bits (≥4).
- STEPS_PER_STAGE, 2, restoring-division iterations per pipeline register; must divide WIDTH.
- TAG_WIDTH, 8, width of the passthrough tag.
- clk_in  input  1  clock; all logic on rising edge.
- rst_in  input  1  reset, synchronous and active-high.
- dividend_in  input  WIDTH  dividend.
- divisor_in  input  WIDTH  divisor.
- signed_in  input  1  1 = two's-complement operands, 0 = unsigned.
- tag_in  input  TAG_WIDTH  user tag.
- data_valid_in  input  1  request valid.
- ready_out  output  1  block can accept this cycle.
- quotient_out  output  WIDTH  quotient.
- remainder_out  output  WIDTH  remainder.
- tag_out  output  TAG_WIDTH  tag of this result.
- error_out  output  1  divisor was zero; qualified by data_valid_out.
- data_valid_out  output  1  result valid.
- ready_in  input  1  downstream accepts result.
- busy_out  output  1  any stage holds a valid operation.

## Operation
- Transfer in when data_valid_in & ready_out; transfer out when data_valid_out & ready_in.
- Pipeline structure, N = WIDTH/STEPS_PER_STAGE:
  - Stage 0 registers the operands. In signed mode it captures the signs and takes absolute values. It also records a zero-divisor flag.
  - Stages 1..N each perform STEPS_PER_STAGE restoring iterations, MSB first. Each iteration shifts the partial remainder left by one bit, shifts in the next dividend bit, subtracts the divisor if the result is ≥ divisor, and records the quotient bit.
  - Stage N+1 is the output register. It applies sign correction and carries the special-case overrides listed below.
- Signed rules (truncating division):
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Dividend = quotient·divisor + remainder holds in all non-error cases.
- Divisor zero:
  - quotient_out = all ones.
  - remainder_out = dividend_in unmodified.
  - error_out = 1.
  - Applies in both modes.
- Signed overflow (most-negative / −1):
  - quotient_out = most-negative value.
  - remainder_out = 0.
  - error_out = 0.
- Valid, tag, mode and special-case flags travel with the data through every stage.
- Stall:
  - stall = data_valid_out & ~ready_in.
  - While stall is high, every stage holds its contents and ready_out = 0.
  - When stall is low, ready_out = 1 (no bubble collapsing).
- busy_out = OR of all stage valid bits.

## Timing
- Latency L = N + 2 cycles from the accepting edge to data_valid_out, with no stalls. WIDTH=8, STEPS_PER_STAGE=2 gives L = 6.
- Throughput: one operation per cycle when ready_in stays high.
- Reset:
  - Clears all stage valid bits.
  - Resets outputs: data_valid_out = 0, error_out = 0, busy_out = 0, quotient_out = 0, remainder_out = 0, tag_out = 0.
  - ready_out = 1 from the first cycle after reset.
  - Operations in flight when reset is asserted are discarded and never emitted.
- Output register is stable while data_valid_out & ~ready_in; no output may change during a stall.
- Simultaneous input accept and output release in the same cycle is legal and loses nothing.
- data_valid_in while ready_out = 0: the request is not accepted. The source must hold its inputs stable until it is accepted.

## Configuration
- PIPELINED_DIVIDER_SIGNED_EN.
  - Defined: signed_in is honoured; sign capture, absolute value, sign correction and the overflow override are compiled in.
  - Undefined: signed_in is ignored and all operations are unsigned. The sign logic and overflow override are removed. Divide-by-zero handling is unchanged.

## Test plan
All scenarios use WIDTH=8, STEPS_PER_STAGE=2, so L=6.
- Unsigned 200/7, tag 0x3A → after 6 cycles: q=28, r=4, tag_out=0x3A, error_out=0.
- Signed −7/2 (0xF9/0x02) → q=0xFD (−3), r=0xFF (−1). Signed 7/−2 → q=0xFD, r=0x01.
- 55/0, either mode → q=0xFF, r=55, error_out=1. Signed 0x80/0xFF → q=0x80, r=0, error_out=0.
- 20 back-to-back random ops with ready_in held high:
  - Results appear on 20 consecutive cycles, in order, with tags matching.
  - Every result matches the reference model.
- Backpressure:
  - Drop ready_in for 3 cycles mid-stream → ready_out=0 and all outputs frozen for those cycles.
  - On release, the stream resumes with no loss or duplication.
- Assert rst_in with 4 ops in flight → busy_out=0 and data_valid_out=0 next cycle, none of the 4 results ever appear, and a new op issued afterwards returns after 6 cycles.

Source files
------------

// File: rtl/pipelined_divider.sv
// Pipelined restoring divider with tag passthrough; optional signed mode via PIPELINED_DIVIDER_SIGNED_EN.
// Latency WIDTH/STEPS_PER_STAGE + 2 cycles, one result per cycle.
// Backpressure: a held output (data_valid_out & ~ready_in) freezes every stage and drops ready_out.
`timescale 1ns/1ps
module pipelined_divider #(
    parameter int WIDTH           = 32,
    parameter int STEPS_PER_STAGE = 2,
    parameter int TAG_WIDTH       = 8
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic [WIDTH-1:0]     dividend_in,
    input  logic [WIDTH-1:0]     divisor_in,
    input  logic                 signed_in,
    input  logic [TAG_WIDTH-1:0] tag_in,
    input  logic                 data_valid_in,
    output logic                 ready_out,
    output logic [WIDTH-1:0]     quotient_out,
    output logic [WIDTH-1:0]     remainder_out,
    output logic [TAG_WIDTH-1:0] tag_out,
    output logic                 error_out,
    output logic                 data_valid_out,
    input  logic                 ready_in,
    output logic                 busy_out
);
    localparam int N = WIDTH / STEPS_PER_STAGE;

    // quo starts as the (absolute) dividend; dividend bits shift out the top while quotient bits shift in below
    typedef struct packed {
        logic [TAG_WIDTH-1:0] tag;
        logic                 dz;
`ifdef PIPELINED_DIVIDER_SIGNED_EN
        logic                 neg_q;
        logic                 neg_r;
        logic                 ovf;
`endif
        logic [WIDTH-1:0]     rem;
        logic [WIDTH-1:0]     quo;
        logic [WIDTH-1:0]     dvs;
    } stage_t;

    logic [N:0]   stage_vld;
    stage_t       stage_dat [0:N];
    stage_t       stage_nxt [1:N];
    stage_t       stage_in;
    logic         stall;
    logic         accept;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;
    logic [WIDTH-1:0] unused_dvs;

    assign stall      = data_valid_out & ~ready_in;
    assign ready_out  = ~stall;
    assign accept     = data_valid_in & ready_out;
    assign busy_out   = (|stage_vld) | data_valid_out;
    assign unused_dvs = stage_dat[N].dvs;

    function automatic stage_t iterate(input stage_t s);
        stage_t           o;
        logic [WIDTH:0]   t;
        o = s;
        for (int i = 0; i < STEPS_PER_STAGE; i++) begin
            t     = {o.rem, o.quo[WIDTH-1]};
            o.quo = {o.quo[WIDTH-2:0], 1'b0};
            if (t >= {1'b0, o.dvs}) begin
                t        = t - {1'b0, o.dvs};
                o.quo[0] = 1'b1;
            end
            o.rem = t[WIDTH-1:0];
        end
        return o;
    endfunction

`ifdef PIPELINED_DIVIDER_SIGNED_EN
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    logic sgn_dvd;
    logic sgn_dvs;
    assign sgn_dvd = signed_in & dividend_in[WIDTH-1];
    assign sgn_dvs = signed_in & divisor_in[WIDTH-1];
`else
    logic unused_signed;
    assign unused_signed = signed_in;
`endif

    // A zero divisor skips sign handling so the raw dividend falls out as the remainder
    always_comb begin
        stage_in     = '0;
        stage_in.tag = tag_in;
        stage_in.dz  = (divisor_in == '0);
        stage_in.quo = dividend_in;
        stage_in.dvs = divisor_in;
`ifdef PIPELINED_DIVIDER_SIGNED_EN
        if (!stage_in.dz) begin
            if (sgn_dvd) stage_in.quo = -dividend_in;
            if (sgn_dvs) stage_in.dvs = -divisor_in;
            stage_in.neg_q = sgn_dvd ^ sgn_dvs;
            stage_in.neg_r = sgn_dvd;
        end
        stage_in.ovf = signed_in & (dividend_in == MOST_NEG) & (divisor_in == '1);
`endif
    end

    always_comb begin
        for (int k = 1; k <= N; k++) stage_nxt[k] = iterate(stage_dat[k-1]);
    end

    always_comb begin
        q_fix = stage_dat[N].quo;
        r_fix = stage_dat[N].rem;
`ifdef PIPELINED_DIVIDER_SIGNED_EN
        if (stage_dat[N].neg_q) q_fix = -stage_dat[N].quo;
        if (stage_dat[N].neg_r) r_fix = -stage_dat[N].rem;
        if (stage_dat[N].ovf) begin
            q_fix = MOST_NEG;
            r_fix = '0;
        end
`endif
        if (stage_dat[N].dz) q_fix = '1;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            stage_vld      <= '0;
            data_valid_out <= 1'b0;
            quotient_out   <= '0;
            remainder_out  <= '0;
            tag_out        <= '0;
            error_out      <= 1'b0;
        end else if (!stall) begin
            stage_vld[0] <= accept;
            if (accept) stage_dat[0] <= stage_in;
            for (int k = 1; k <= N; k++) begin
                stage_vld[k] <= stage_vld[k-1];
                stage_dat[k] <= stage_nxt[k];
            end
            data_valid_out <= stage_vld[N];
            if (stage_vld[N]) begin
                quotient_out  <= q_fix;
                remainder_out <= r_fix;
                tag_out       <= stage_dat[N].tag;
                error_out     <= stage_dat[N].dz;
            end
        end
    end
endmodule
